clock_step_controller: RTL
==========================

CLOCK_STEP_CONTROLLER -- requirements
Module: clock_step_controller

Interface
REQ-001 Parameter: DIV_W, 8, width of the divide-ratio field.
REQ-002 Parameter: DIV_RST, 1, divide ratio loaded at reset; must be less than or equal to 2^DIV_W-1.
REQ-003 Port: clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: run  input  1  level; request free-running enable generation.
REQ-006 Port: step  input  1  level, sampled; request exactly one enable period.
REQ-007 Port: div_val  input  DIV_W  new divide ratio N; the enable period is N+1 clk cycles.
REQ-008 Port: div_load  input  1  one-cycle strobe that captures div_val.
REQ-009 Port: clk_en  output  1  registered one-cycle enable pulse for the downstream datapath.
REQ-010 Port: step_done  output  1  registered pulse coincident with the clk_en of a STEP period.
REQ-011 Port: running  output  1  high whenever the state is RUN or STEP.

Function
REQ-012 The controller SHALL implement three states:
- IDLE: cnt held at 0; clk_en is 0.
- RUN: free-running enable generation.
- STEP: generates one enable period, then stops.
REQ-013 In IDLE, the controller SHALL apply these transitions, with run taking priority over step:
- run=1 -> RUN.
- else step=1 -> STEP.
- cnt is set to 0 on entry to either state.
REQ-014 In RUN or STEP, each cycle the controller SHALL:
- if cnt==div_cur (period boundary): set cnt<=0 and clk_en<=1;
- otherwise: set cnt<=cnt+1 and clk_en<=0.
REQ-015 Latency: if the state is entered at edge k, the first clk_en SHALL be high in the cycle after edge k+div_cur+1; subsequent pulses follow every div_cur+1 cycles.
REQ-016 div_cur=0 SHALL produce clk_en high every cycle while in RUN.
REQ-017 When run deasserts in RUN, the controller SHALL finish the current period, including its clk_en pulse, then return to IDLE at that boundary; no truncated period is issued.
REQ-018 STEP SHALL issue exactly one clk_en with step_done, then go to IDLE; step or run changes during STEP SHALL be ignored until IDLE re-evaluates.
REQ-019 step asserted while in RUN SHALL be ignored.
REQ-020 div_load in IDLE SHALL write div_val directly into div_cur.
REQ-021 div_load in RUN or STEP SHALL:
- store div_val into div_pend and set the pending flag;
- copy div_pend into div_cur at the next period boundary and clear pending.
REQ-022 div_load coinciding with a boundary SHALL write div_val directly into div_cur, so it governs the next period; any older pending value SHALL be discarded.
REQ-023 A second div_load before the boundary SHALL overwrite div_pend; the last value wins.
REQ-024 cnt SHALL be DIV_W bits wide, compare with equality only, and never exceed div_cur.
REQ-025 running SHALL be a decode of the registered state.

Reset
REQ-026 rst_n low SHALL immediately, without waiting for clk, force:
- state = IDLE, cnt = 0;
- div_cur = DIV_RST, div_pend = 0, pending = 0;
- clk_en = 0, step_done = 0, running = 0.
REQ-027 Reset asserted mid-period SHALL abort the period with no further pulses; after release, operation resumes only from IDLE evaluation at the first clk edge.

Configuration
REQ-028 Macro CLKCTL_PULSE_COUNT_EN SHALL control the pulse counter:
- Defined: adds output port pulse_cnt (16 bits). It increments by 1 on each cycle clk_en is high, wraps 0xFFFF->0x0000, is cleared only by reset, and has a reset value of 0.
- Undefined: the pulse_cnt port and its logic are absent; all other behaviour is identical.

Verification
REQ-029 Reset, then run=1 with div_cur=1 (DIV_RST) -> first clk_en 2 cycles after entering RUN, then high 1 of every 2 cycles; running=1.
REQ-030 In IDLE, div_load with div_val=3, then step=1 for one cycle -> exactly one clk_en, in the cycle after edge k+4, with step_done=1 in the same cycle; then IDLE and running=0.
REQ-031 run=1 with div_cur=4; div_load with div_val=0 at cnt=2 -> the current period stays 5 cycles, after which clk_en is high every cycle.
REQ-032 run=1 with div_cur=5; run dropped at cnt=1 -> one more clk_en at the boundary 4 cycles later, then IDLE with no further pulses.
REQ-033 rst_n pulled low mid-period at cnt=3 with div_cur=7 -> outputs go to 0 without a clk edge; no clk_en appears after release while run=0.
REQ-034 With CLKCTL_PULSE_COUNT_EN defined, pulse_cnt preloaded to 0xFFFE via 2 pulses short of wrap, then div_cur=0 and run for 3 cycles -> pulse_cnt reads 0xFFFF, 0x0000, 0x0001.

Source files
------------

// File: rtl/clock_step_controller.sv
// Enable-pulse generator with free-running (RUN) and single-period (STEP) modes.
// Optional 16-bit pulse counter output is built when CLKCTL_PULSE_COUNT_EN is defined.
module clock_step_controller #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             step,
  input  logic [DIV_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_en,
  output logic             step_done,
  output logic             running
`ifdef CLKCTL_PULSE_COUNT_EN
  ,
  output logic [15:0]      pulse_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] div_pend_q, div_pend_d;
  logic             pending_q, pending_d;
  logic             clk_en_q, clk_en_d;
  logic             step_done_q, step_done_d;
  logic             boundary;

  assign boundary = (cnt_q == div_cur_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_cur_d   = div_cur_q;
    div_pend_d  = div_pend_q;
    pending_d   = pending_q;
    clk_en_d    = 1'b0;
    step_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (run) begin
          state_d = S_RUN;
        end else if (step) begin
          state_d = S_STEP;
        end
        if (div_load) begin
          div_cur_d = div_val;
          pending_d = 1'b0;
        end
      end

      S_RUN, S_STEP: begin
        if (boundary) begin
          cnt_d    = '0;
          clk_en_d = 1'b1;
          if (state_q == S_STEP) begin
            step_done_d = 1'b1;
            state_d     = S_IDLE;
          end else if (!run) begin
            state_d = S_IDLE;
          end
          // A load landing on the boundary wins over any older pending ratio.
          if (div_load) begin
            div_cur_d = div_val;
            pending_d = 1'b0;
          end else if (pending_q) begin
            div_cur_d = div_pend_q;
            pending_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
          if (div_load) begin
            div_pend_d = div_val;
            pending_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_cur_q   <= DIV_W'(DIV_RST);
      div_pend_q  <= '0;
      pending_q   <= 1'b0;
      clk_en_q    <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_cur_q   <= div_cur_d;
      div_pend_q  <= div_pend_d;
      pending_q   <= pending_d;
      clk_en_q    <= clk_en_d;
      step_done_q <= step_done_d;
    end
  end

  assign clk_en    = clk_en_q;
  assign step_done = step_done_q;
  assign running   = (state_q != S_IDLE);

`ifdef CLKCTL_PULSE_COUNT_EN
  logic [15:0] pulse_cnt_q, pulse_cnt_d;

  // Counts pulses already issued; wraps naturally at 16 bits.
  always_comb begin
    pulse_cnt_d = pulse_cnt_q + 16'(clk_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt_q <= '0;
    end else begin
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

  assign pulse_cnt = pulse_cnt_q;
`endif

endmodule
